hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard/stall controller for the 5-stage RISC-V core. Drives the enable and
//  flush inputs of the PC and IF/ID, ID/EX, EX/MEM pipeline registers (enable-gated flops).
//  Handles load-use stalls, taken-branch flushes and multi-cycle mul/div (MD) stalls,
//  with an MD timeout watchdog and a stall-cycle performance counter.
// PARAMETERS
//  REG_W      5    register address width
//  CNT_W      16   width of stall_cycles counter
//  MD_MAX     64   max MD_WAIT cycles before timeout (>=2)
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-high reset
//  id_rs1,id_rs2  in   REG_W  source regs of instruction in ID
//  id_use1,id_use2 in  1      ID instruction actually reads rs1/rs2
//  ex_rd          in   REG_W  dest reg of instruction in EX
//  ex_memread     in   1      EX instruction is a load
//  branch_taken   in   1      EX resolved taken branch/jump
//  md_start       in   1      EX holds an MD op (level, valid while it sits in EX)
//  md_done        in   1      MD unit result ready this cycle
//  pc_en,ifid_en,idex_en out 1  enables for PC / IF-ID / ID-EX registers
//  ifid_flush,idex_flush,exmem_flush out 1  synchronous clear (bubble) requests
//  md_timeout     out  1      sticky: MD op exceeded MD_MAX cycles
//  stall_cycles   out  CNT_W  count of cycles with pc_en=0, saturating
// BEHAVIOUR
//  State: RUN, MD_WAIT, ERR (2-bit reg, async reset to RUN). Outputs combinational from
//  state+inputs except md_timeout, stall_cycles (registered).
//  Reset (async, any state): state=RUN, wait counter=0, md_timeout=0, stall_cycles=0.
//   While reset high: pc_en=ifid_en=idex_en=1, all flushes=0.
//  Default (RUN, no hazard): all enables=1, all flushes=0.
//  Load-use hz = ex_memread & ex_rd!=0 & ((id_use1 & id_rs1==ex_rd)|(id_use2 & id_rs2==ex_rd)).
//  Priority in RUN (highest first):
//   1 md_start & !md_done: pc_en=ifid_en=idex_en=0, exmem_flush=1; next=MD_WAIT, cnt=1.
//   1a md_start & md_done same cycle: no stall, treated as default (single-cycle MD).
//   2 branch_taken: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1 (ID squashed, so
//     a coincident load-use hz is ignored; no stall).
//   3 load-use hz: pc_en=ifid_en=0, idex_flush=1 (one bubble). No state change; hz
//     clears next cycle as load moves to MEM.
//  MD_WAIT: while !md_done: same stall outputs as case 1; cnt++.
//   md_done=1: all enables=1, exmem_flush=0 (result advances); branch_taken/load-use
//     rules of RUN apply this cycle; next=RUN, cnt=0.
//   cnt==MD_MAX & !md_done: next=ERR, md_timeout<=1.
//  ERR: pipeline frozen (pc_en=ifid_en=idex_en=0, exmem_flush=1); md_done ignored;
//   only reset exits. md_timeout stays 1.
//  md_done outside MD_WAIT and without md_start: ignored.
//  stall_cycles: +1 on each posedge where pc_en=0 (not during reset); holds at 2^CNT_W-1.
//  ex_rd=0 never causes a stall (x0).
// TESTING
//  1 ex_memread=1,ex_rd=5,id_rs1=5,id_use1=1 one cycle -> pc_en=ifid_en=0,idex_flush=1
//    that cycle only; stall_cycles 0->1. Same with ex_rd=0 -> no stall.
//  2 Load-use hz + branch_taken same cycle -> ifid_flush=idex_flush=1, pc_en=1,
//    stall_cycles unchanged.
//  3 md_start at cycle 0, md_done at cycle 4 -> enables low cycles 0-3, exmem_flush=1
//    cycles 0-3, all high cycle 4, state RUN at cycle 5, stall_cycles=4.
//  4 md_start with md_done same cycle -> no stall, state stays RUN.
//  5 MD_MAX=4, md_start held, md_done never -> ERR after 4 MD_WAIT cycles, md_timeout=1,
//    pipeline frozen; later md_done=1 has no effect; reset -> RUN, md_timeout=0.
//  6 Reset asserted mid-MD_WAIT (async, between edges) -> state RUN, enables=1
//    immediately, counters 0; stall_cycles saturation checked with CNT_W=3 (holds at 7).

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_stall_ctrl
//  Purpose  : Hazard and stall controller for the 5-stage RISC-V pipeline.
//             It drives the enables of the PC and the IF/ID and ID/EX
//             registers, and the bubble (flush) requests of the IF/ID, ID/EX
//             and EX/MEM registers. It covers load-use stalls, taken-branch
//             squashes and multi-cycle mul/div (MD) stalls. A watchdog
//             freezes the pipeline when an MD operation never completes.
//  Ports    : clk, reset (async, active-high)
//             id_rs1/id_rs2/id_use1/id_use2 - sources read by the ID instr
//             ex_rd/ex_memread               - EX destination, EX is a load
//             branch_taken                   - EX resolved a taken branch
//             md_start/md_done               - MD op in EX / MD result ready
//             pc_en/ifid_en/idex_en          - register enables
//             ifid_flush/idex_flush/exmem_flush - bubble requests
//             md_timeout   - sticky MD watchdog flag (registered)
//             stall_cycles - saturating count of cycles with pc_en=0
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16,
  parameter int MD_MAX = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W = $clog2(MD_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_MD_WAIT = 2'd1;
  localparam logic [1:0] S_ERR     = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              timeout_set;
  logic              load_use_hz;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign load_use_hz = ex_memread && (ex_rd != '0) &&
                       ((id_use1 && (id_rs1 == ex_rd)) ||
                        (id_use2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;

    case (state)
      S_RUN: begin
        if (md_start && !md_done) begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_flush  = 1'b1;
          state_nxt    = S_MD_WAIT;
          wait_cnt_nxt = WAIT_ONE;
        end else if (branch_taken) begin
          // ID is squashed, so any coincident load-use hazard is moot.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use_hz) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end

      S_MD_WAIT: begin
        if (md_done) begin
          // Result advances this cycle; normal RUN hazard rules apply.
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use_hz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
        end else begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          if (wait_cnt == WAIT_MAX) begin
            state_nxt   = S_ERR;
            timeout_set = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_ONE;
          end
        end
      end

      S_ERR: begin
        // Frozen until reset; md_done is deliberately ignored here.
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
      end

      default: begin
        state_nxt    = S_RUN;
        wait_cnt_nxt = '0;
      end
    endcase

    // While reset is held the pipeline must see a clean "run" view even if
    // the inputs describe a hazard.
    if (reset) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_RUN;
      wait_cnt     <= '0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      md_timeout <= md_timeout | timeout_set;
      if (!pc_en && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_stall_ctrl
//  Purpose  : Self-checking bench for hazard_stall_ctrl. Directed scenarios
//             followed by randomized traffic, all compared against a
//             behavioural model of the pipeline-control rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int REG_W  = 5;
  localparam int CNT_W  = 3;
  localparam int MD_MAX = 4;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic             id_use1 = 1'b0, id_use2 = 1'b0, ex_memread = 1'b0;
  logic             branch_taken = 1'b0, md_start = 1'b0, md_done = 1'b0;
  logic             pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;
  logic             md_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: is an MD op outstanding, how many stalled MD cycles
  // it has consumed, whether the watchdog tripped, and the raw stall tally.
  bit m_in_md;
  int m_waited;
  bit m_frozen;
  bit m_timeout;
  int m_stalls;

  hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MD_MAX(MD_MAX)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken),
    .md_start(md_start), .md_done(md_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_in_md = 0; m_waited = 0; m_frozen = 0; m_timeout = 0; m_stalls = 0;
  endfunction

  // Ctrl vector order: {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush}
  function automatic logic [5:0] model_ctrl();
    bit hz;
    hz = ex_memread && (ex_rd != 0) &&
         ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
    if (m_frozen)                               return 6'b000001;
    if (m_in_md && !md_done)                    return 6'b000001;
    if (!m_in_md && md_start && !md_done)       return 6'b000001;
    if (branch_taken)                           return 6'b111110;
    if (hz)                                     return 6'b001010;
    return 6'b111000;
  endfunction

  function automatic void model_advance(input logic [5:0] ctrl);
    if (!ctrl[5]) m_stalls++;
    if (m_frozen) return;
    if (m_in_md) begin
      if (md_done) begin
        m_in_md = 0; m_waited = 0;
      end else if (m_waited == MD_MAX) begin
        m_frozen = 1; m_timeout = 1;
      end else begin
        m_waited++;
      end
    end else if (md_start && !md_done) begin
      m_in_md = 1; m_waited = 1;
    end
  endfunction

  function automatic int sat_cnt();
    return (m_stalls > SAT) ? SAT : m_stalls;
  endfunction

  // One clock cycle: drive inputs on the falling edge, check 1 time unit
  // later, then advance the model for the coming rising edge.
  task automatic cycle(input string tag,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic ms, input logic md);
    logic [5:0] exp_ctrl;
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_use1 = u1; id_use2 = u2;
    ex_rd = rd; ex_memread = mr; branch_taken = br; md_start = ms; md_done = md;
    #1;
    exp_ctrl = model_ctrl();
    check_eq({tag, "_ctrl"},
             {26'd0, pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush},
             {26'd0, exp_ctrl});
    check_eq({tag, "_tmo"}, {31'd0, md_timeout}, {31'd0, m_timeout});
    check_eq({tag, "_cnt"}, {29'd0, stall_cycles}, sat_cnt());
    model_advance(exp_ctrl);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset asserted between edges with a live load-use hazard on the inputs.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    id_rs1 = 5'd7; id_use1 = 1'b1; ex_rd = 5'd7; ex_memread = 1'b1;
    reset = 1'b1;
    #1;
    check_eq({tag, "_rst_ctrl"},
             {26'd0, pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush},
             32'h38);
    check_eq({tag, "_rst_tmo"}, {31'd0, md_timeout}, 32'd0);
    check_eq({tag, "_rst_cnt"}, {29'd0, stall_cycles}, 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    id_use1 = 1'b0; ex_memread = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    reset = 1'b0;

    // Load-use on rs1 stalls exactly one cycle; x0 destination never stalls.
    do_reset("t1");
    cycle("t1_hz", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle("t1_after");
    check_eq("t1_cnt_is_1", {29'd0, stall_cycles}, 32'd1);
    cycle("t1_x0", 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("t1_rs2", 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle("t1_nouse", 5'd9, 5'd9, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);

    // Branch beats load-use: squash, no stall.
    do_reset("t2");
    cycle("t2_br_hz", 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("t2_after");
    check_eq("t2_cnt_is_0", {29'd0, stall_cycles}, 32'd0);

    // MD op started at cycle 0, result at cycle 4.
    do_reset("t3");
    for (int i = 0; i < 4; i++)
      cycle("t3_wait", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("t3_done", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("t3_run");
    check_eq("t3_cnt_is_4", {29'd0, stall_cycles}, 32'd4);

    // Single-cycle MD op.
    do_reset("t4");
    cycle("t4_md1", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("t4_run");

    // Watchdog: no md_done ever, then a late md_done must be ignored.
    do_reset("t5");
    for (int i = 0; i < 7; i++)
      cycle("t5_hang", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t5_timeout", {31'd0, md_timeout}, 32'd1);
    cycle("t5_lated", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("t5_frozen");
    idle("t5_sat");
    check_eq("t5_cnt_sat", {29'd0, stall_cycles}, SAT);
    do_reset("t5");
    idle("t5_run");

    // Reset mid-MD_WAIT, then the pipeline must run freely.
    do_reset("t6");
    cycle("t6_md", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle("t6_md", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset("t6");
    idle("t6_run");

    // Randomized traffic with periodic resets to escape the frozen state.
    for (int n = 0; n < 800; n++) begin
      logic [4:0] rs1, rs2, rd;
      logic u1, u2, mr, br, ms, md;
      if (n % 60 == 59) do_reset("rnd");
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      ms  = ($urandom_range(0, 5) == 0);
      md  = ($urandom_range(0, 3) == 0);
      // An MD op in EX is neither a load nor a branch.
      mr  = ms ? 1'b0 : 1'($urandom_range(0, 1));
      br  = ms ? 1'b0 : ($urandom_range(0, 4) == 0);
      cycle("rnd", rs1, rs2, u1, u2, rd, mr, br, ms, md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
